// File: rtl/core_traffic_driver.sv
// Core-side traffic initiator: writes a pattern over N_REQUESTS words, reads it back and checks it.
// Optional response watchdog is built when TRAFFIC_TIMEOUT_EN is defined.
module core_traffic_driver #(
  parameter int unsigned                BW_ACCESS_ADDR = 32,
  parameter int unsigned                BW_DATA_WORD   = 32,
  parameter int unsigned                N_REQUESTS     = 256,
  parameter logic [BW_ACCESS_ADDR-1:0]  BASE_ADDR      = '0,
  parameter int unsigned                ADDR_STRIDE    = 4,
  parameter logic [31:0]                DATA_SEED      = 32'hA5A50000,
  parameter int unsigned                BW_COUNT       = 16,
  parameter int unsigned                TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      stall_i,
  output logic                      core_request_o,
  output logic                      core_wren_o,
  output logic [BW_ACCESS_ADDR-1:0] core_addr_o,
  output logic [BW_DATA_WORD-1:0]   core_data_o,
  input  logic                      core_valid_i,
  input  logic [BW_DATA_WORD-1:0]   core_data_i,
  output logic                      done_o,
  output logic                      error_o,
  output logic [BW_COUNT-1:0]       error_count_o,
  output logic [BW_COUNT-1:0]       request_count_o
);

  // state    | meaning
  // IDLE     | waiting for start_i
  // WR_ISSUE | issue write of word index when not stalled
  // WR_WAIT  | write outstanding, waiting for core_valid_i
  // RD_ISSUE | issue read of word index when not stalled
  // RD_WAIT  | read outstanding, compare returned word on core_valid_i
  // DONE     | run finished, hold results until start_i drops
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE} state_t;

  localparam logic [BW_DATA_WORD-1:0]   SEED       = BW_DATA_WORD'(DATA_SEED);
  localparam logic [BW_ACCESS_ADDR-1:0] STRIDE     = BW_ACCESS_ADDR'(ADDR_STRIDE);
  localparam logic [BW_COUNT-1:0]       LAST_INDEX = BW_COUNT'(N_REQUESTS - 1);
  localparam logic [BW_COUNT-1:0]       COUNT_ONE  = BW_COUNT'(1);

  state_t              state;
  logic [BW_COUNT-1:0] index;
  logic                in_wait;
  logic                timeout;

  function automatic logic [BW_DATA_WORD-1:0] pattern(input logic [BW_COUNT-1:0] idx);
    logic [BW_COUNT+7:0] mix;
    mix = {idx, ~idx[7:0]};
    return SEED ^ BW_DATA_WORD'(mix);
  endfunction

  function automatic logic [BW_COUNT-1:0] sat_inc(input logic [BW_COUNT-1:0] value);
    return (value == '1) ? value : value + COUNT_ONE;
  endfunction

  assign in_wait = (state == WR_WAIT) || (state == RD_WAIT);

`ifdef TRAFFIC_TIMEOUT_EN
  localparam int unsigned      BW_WD   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW_WD-1:0] WD_LAST = BW_WD'(TIMEOUT_CYCLES - 1);

  logic [BW_WD-1:0] watchdog;

  // Counts only the cycles a request sits unanswered; any response restarts it.
  always_ff @(posedge clock_i) begin
    if (reset_i || !in_wait || core_valid_i) watchdog <= '0;
    else                                     watchdog <= watchdog + BW_WD'(1);
  end

  assign timeout = in_wait && !core_valid_i && (watchdog == WD_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state           <= IDLE;
      index           <= '0;
      core_request_o  <= 1'b0;
      core_wren_o     <= 1'b0;
      core_addr_o     <= '0;
      core_data_o     <= '0;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
      error_count_o   <= '0;
      request_count_o <= '0;
    end else begin
      core_request_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            error_o         <= 1'b0;
            error_count_o   <= '0;
            request_count_o <= '0;
            index           <= '0;
            core_addr_o     <= BASE_ADDR;
            state           <= WR_ISSUE;
          end
        end
        WR_ISSUE, RD_ISSUE: begin
          if (!stall_i) begin
            core_request_o <= 1'b1;
            core_wren_o    <= (state == WR_ISSUE);
            core_data_o    <= (state == WR_ISSUE) ? pattern(index) : '0;
            state          <= (state == WR_ISSUE) ? WR_WAIT : RD_WAIT;
          end
        end
        WR_WAIT, RD_WAIT: begin
          // The response may coincide with the request strobe, which is already visible in WAIT.
          if (core_valid_i) begin
            request_count_o <= sat_inc(request_count_o);
            if ((state == RD_WAIT) && (core_data_i != pattern(index))) begin
              error_o       <= 1'b1;
              error_count_o <= sat_inc(error_count_o);
            end
            if (index == LAST_INDEX) begin
              index       <= '0;
              core_addr_o <= BASE_ADDR;
              done_o      <= (state == RD_WAIT);
              state       <= (state == WR_WAIT) ? RD_ISSUE : DONE;
            end else begin
              index       <= index + COUNT_ONE;
              core_addr_o <= core_addr_o + STRIDE;
              state       <= (state == WR_WAIT) ? WR_ISSUE : RD_ISSUE;
            end
          end else if (timeout) begin
            error_o       <= 1'b1;
            error_count_o <= sat_inc(error_count_o);
            done_o        <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (!start_i) begin
            done_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
